// File: rtl/regfile_nr.sv
// Parametrised register file: two combinational read ports, one synchronous
// write port, optional hardwired zero register and write-to-read bypass.
module regfile_nr #(
  parameter  int WIDTH    = 64,
  parameter  int NREGS    = 32,
  parameter  int ZERO_REG = NREGS - 1,
  parameter  int BYPASS   = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWrite,
  input  logic [AW-1:0]    WriteRegister,
  input  logic [WIDTH-1:0] WriteData,
  input  logic [AW-1:0]    ReadRegister1,
  input  logic [AW-1:0]    ReadRegister2,
  output logic [WIDTH-1:0] ReadData1,
  output logic [WIDTH-1:0] ReadData2
);

  logic [WIDTH-1:0] mem_q [NREGS];
  logic [WIDTH-1:0] rd1_d;
  logic [WIDTH-1:0] rd2_d;
  logic             wr_ok;

  assign wr_ok = RegWrite && (int'(WriteRegister) != ZERO_REG);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else if (wr_ok) begin
      mem_q[WriteRegister] <= WriteData;
    end
  end

  // Binary 2:1 mux tree, reduced in place: address bit 0 at the leaves,
  // bit AW-1 at the root.
  function automatic logic [WIDTH-1:0] tree_rd(input logic [AW-1:0] addr);
    logic [WIDTH-1:0] node [NREGS];
    for (int i = 0; i < NREGS; i++) node[i] = mem_q[i];
    for (int b = 0; b < AW; b++) begin
      for (int j = 0; j < (NREGS >> (b + 1)); j++) begin
        node[j] = addr[b] ? node[2*j+1] : node[2*j];
      end
    end
    return node[0];
  endfunction

  function automatic logic [WIDTH-1:0] port_rd(input logic [AW-1:0] addr);
    logic [WIDTH-1:0] val;
    val = tree_rd(addr);
    if (reset || int'(addr) == ZERO_REG) begin
      val = '0;
    end else if (BYPASS != 0 && RegWrite && WriteRegister == addr) begin
      val = WriteData;
    end
    return val;
  endfunction

  always_comb begin
    rd1_d = port_rd(ReadRegister1);
    rd2_d = port_rd(ReadRegister2);
  end

  assign ReadData1 = rd1_d;
  assign ReadData2 = rd2_d;

endmodule

// File: tb/tb_regfile_nr.sv
// Directed bench for regfile_nr: default, no-bypass and small/no-zero-reg
// instances, checked against a queue of expected read values.
module tb_regfile_nr;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic [4:0]  wr = '0;
  logic [63:0] wd = '0;
  logic [4:0]  rd1 = '0;
  logic [4:0]  rd2 = '0;
  logic [63:0] d_rd1, d_rd2, n_rd1, n_rd2;

  logic        p_we = 1'b0;
  logic [2:0]  p_wr = '0;
  logic [31:0] p_wd = '0;
  logic [2:0]  p_rd1 = '0;
  logic [2:0]  p_rd2 = '0;
  logic [31:0] p_o1, p_o2;

  int n_assert = 0;
  int n_fail = 0;

  typedef struct {
    string       tag;
    int          src;
    logic [63:0] val;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  regfile_nr u_dut (
    .clk(clk), .reset(reset), .RegWrite(we), .WriteRegister(wr), .WriteData(wd),
    .ReadRegister1(rd1), .ReadRegister2(rd2), .ReadData1(d_rd1), .ReadData2(d_rd2)
  );

  regfile_nr #(.BYPASS(0)) u_nb (
    .clk(clk), .reset(reset), .RegWrite(we), .WriteRegister(wr), .WriteData(wd),
    .ReadRegister1(rd1), .ReadRegister2(rd2), .ReadData1(n_rd1), .ReadData2(n_rd2)
  );

  regfile_nr #(.WIDTH(32), .NREGS(8), .ZERO_REG(8)) u_p (
    .clk(clk), .reset(reset), .RegWrite(p_we), .WriteRegister(p_wr), .WriteData(p_wd),
    .ReadRegister1(p_rd1), .ReadRegister2(p_rd2), .ReadData1(p_o1), .ReadData2(p_o2)
  );

  function automatic logic [63:0] observe(input int src);
    case (src)
      0:       return d_rd1;
      1:       return d_rd2;
      2:       return n_rd1;
      3:       return n_rd2;
      4:       return {32'h0, p_o1};
      default: return {32'h0, p_o2};
    endcase
  endfunction

  task automatic push(input string tag, input int src, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.src = src;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t        e;
    logic [63:0] obs;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs = observe(e.src);
      n_assert++;
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pat(input int i);
    return (i == 31) ? 64'h0 : 64'(i) * 64'h0101_0101_0101_0101;
  endfunction

  initial begin
    // reset state
    #2;
    rd1 = 5'd0; rd2 = 5'd30; p_rd1 = 3'd0; p_rd2 = 3'd7;
    push("rst_rd1", 0, 64'h0); push("rst_rd2", 1, 64'h0);
    push("rst_p1", 4, 64'h0);  push("rst_p2", 5, 64'h0);
    check();
    @(negedge clk); reset = 1'b0;

    // async reset clears stored data between edges
    tick();
    we = 1'b1; wr = 5'd5; wd = 64'hDEAD_BEEF_0000_1234;
    tick();
    we = 1'b0; rd1 = 5'd5; rd2 = 5'd5;
    push("load5_rd1", 0, 64'hDEAD_BEEF_0000_1234);
    push("load5_rd2", 1, 64'hDEAD_BEEF_0000_1234);
    check();
    reset = 1'b1;
    push("rst_mid_rd1", 0, 64'h0); push("rst_mid_rd2", 1, 64'h0);
    check();
    reset = 1'b0;
    push("rst_after_rd1", 0, 64'h0); push("rst_after_nb", 2, 64'h0);
    check();

    // basic write then read
    tick();
    we = 1'b1; wr = 5'd10; wd = 64'h400;
    tick();
    we = 1'b0; rd1 = 5'd10; rd2 = 5'd9;
    push("wr10_rd1", 0, 64'h400); push("rd9_rd2", 1, 64'h0);
    check();

    // zero register ignores writes and bypass
    tick();
    we = 1'b1; wr = 5'd31; wd = '1; rd1 = 5'd31; rd2 = 5'd31;
    push("zr_byp_rd1", 0, 64'h0); push("zr_byp_rd2", 1, 64'h0);
    push("zr_nb_rd1", 2, 64'h0);
    check();
    tick();
    we = 1'b0;
    push("zr_post_rd1", 0, 64'h0); push("zr_post_rd2", 1, 64'h0);
    check();
    rd1 = 5'd10; rd2 = 5'd5;
    push("zr_keep10", 0, 64'h400); push("zr_keep5", 1, 64'h0);
    check();

    // bypass vs no bypass
    tick();
    we = 1'b1; wr = 5'd4; wd = 64'h3;
    tick();
    wd = 64'h7; rd1 = 5'd4; rd2 = 5'd4;
    push("byp_pre_rd1", 0, 64'h7); push("byp_pre_rd2", 1, 64'h7);
    push("nb_pre_rd1", 2, 64'h3);  push("nb_pre_rd2", 3, 64'h3);
    check();
    tick();
    we = 1'b0;
    push("byp_post_rd1", 0, 64'h7); push("nb_post_rd2", 3, 64'h7);
    check();

    // sweep every entry
    for (int i = 0; i < 31; i++) begin
      tick();
      we = 1'b1; wr = 5'(i); wd = pat(i);
    end
    tick();
    we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rd1 = 5'(i); rd2 = 5'(i ^ 31);
      push($sformatf("sweep_rd1_%0d", i), 0, pat(i));
      push($sformatf("sweep_rd2_%0d", i ^ 31), 1, pat(i ^ 31));
      check();
      tick();
    end

    // reset asserted during a write wins
    we = 1'b1; wr = 5'd3; wd = 64'h99; rd1 = 5'd3; rd2 = 5'd3;
    #2 reset = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0; we = 1'b0;
    push("rst_wr_rd1", 0, 64'h0); push("rst_wr_nb", 2, 64'h0);
    check();
    tick();
    we = 1'b1; wd = 64'h55;
    push("first_wr_byp", 0, 64'h55); push("first_wr_nb", 2, 64'h0);
    check();
    tick();
    we = 1'b0;
    push("first_wr_rd1", 0, 64'h55); push("first_wr_nbr", 3, 64'h55);
    check();

    // narrow instance without a zero register
    p_we = 1'b1; p_wr = 3'd7; p_wd = 32'hA5A5_A5A5;
    tick();
    p_we = 1'b0; p_rd1 = 3'd7; p_rd2 = 3'd0;
    push("p_rd7", 4, 64'hA5A5_A5A5); push("p_rd0_pre", 5, 64'h0);
    check();
    tick();
    p_we = 1'b1; p_wr = 3'd0; p_wd = 32'h1234_5678;
    push("p_byp0", 5, 64'h1234_5678);
    check();
    tick();
    p_we = 1'b0;
    push("p_rd0", 5, 64'h1234_5678); push("p_rd7_keep", 4, 64'hA5A5_A5A5);
    check();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_nr.md
Name: regfile_nr

Overview:
- Parametrised register file for the 5-stage pipeline. Replaces the fixed 32-entry read path built from 32:1 bit muxes.
- Provides NREGS entries of WIDTH bits, two combinational read ports and one synchronous write port.
- A hardwired zero register serves as XZR.
- An optional write-to-read bypass lets the decode stage see a value written in the same cycle by writeback.

Parameters:
- WIDTH, 64, data bits per register.
- NREGS, 32, number of registers; power of two, minimum 2.
- ZERO_REG, NREGS-1, index that always reads 0 and ignores writes; set to NREGS to disable the zero register.
- BYPASS, 1, 1 = same-cycle write data is forwarded to the read ports; 0 = reads return only stored contents.
- AW, $clog2(NREGS), address width (derived; not overridden).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all registers.
- RegWrite  input  1  write enable.
- WriteRegister  input  AW  write address.
- WriteData  input  WIDTH  write data.
- ReadRegister1  input  AW  read port 1 address.
- ReadRegister2  input  AW  read port 2 address.
- ReadData1  output  WIDTH  read port 1 data, combinational.
- ReadData2  output  WIDTH  read port 2 data, combinational.

Behaviour:
- Storage: NREGS x WIDTH flops, mem[0..NREGS-1].
- Reset: reset high asynchronously forces every mem entry to 0, independent of clk.
  - While reset is high, ReadData1 and ReadData2 = 0 for all addresses. BYPASS is suppressed during reset.
  - A reset asserted mid-write wins: the entry ends at 0.
  - After reset deasserts, the first write takes effect on the next rising clk edge.
- Write: on rising clk, with reset low and RegWrite=1 and WriteRegister != ZERO_REG, mem[WriteRegister] <= WriteData.
  - A write to ZERO_REG is discarded with no side effect.
  - RegWrite=0 leaves all entries unchanged.
- Read (each port independent, same rules, p = 1 or 2):
  - If ReadRegister_p == ZERO_REG, ReadData_p = 0.
  - Else if BYPASS=1 and RegWrite=1 and WriteRegister == ReadRegister_p, ReadData_p = WriteData (same cycle, before the edge).
  - Else ReadData_p = mem[ReadRegister_p].
- Latency: 0 cycles for reads (combinational from address/bypass inputs); 1 edge for a write to become visible from storage.
- Both ports may read the same address simultaneously, and both may be bypassed in the same cycle.
- Read mux structure: a log2(NREGS)-level binary 2:1 tree per bit, with select bit AW-1 at the root. This generalises the 16:1 + 16:1 + 2:1 decomposition.
- Width rules: addresses are exactly AW bits, so there is no out-of-range index. WriteData is stored unmodified, with no sign extension.
- No X propagation: storage is reset-initialised, so after reset every read is defined.

Test Plan:
- Reset: load mem[5]=64'hDEAD_BEEF_0000_1234, then assert reset for 1 ns between edges. Both ports reading 5 -> 0 immediately. Deassert, read 5 -> 0.
- Write/read: RegWrite=1, WriteRegister=10, WriteData=64'h0000_0000_0000_0400, one edge. Set RegWrite=0, ReadRegister1=10 -> 64'h400; ReadRegister2=9 -> 0.
- Zero register: write 64'hFFFF_FFFF_FFFF_FFFF to 31 with default parameters. Read 31 on both ports -> 0, including during the write cycle with BYPASS=1. All other entries are unchanged.
- Bypass: mem[4]=64'h3. In the same cycle drive RegWrite=1, WriteRegister=4, WriteData=64'h7, ReadRegister1=4, ReadRegister2=4 -> both ports 64'h7 before the edge and after it. Repeat with BYPASS=0 -> 64'h3 before the edge, 64'h7 after.
- Sweep: for all i in 0..30 write WriteData = i*64'h0101_0101_0101_0101, then read every i on port 1 and i^5'b11111 on port 2. Expect the matching patterns, with 0 wherever an address is 31.
- Parametrisation: instantiate WIDTH=32, NREGS=8, ZERO_REG=8 (zero register disabled). Write 32'hA5A5_A5A5 to 7, then read 7 -> 32'hA5A5_A5A5. Write to 0 -> stored and read back.
